// File: rtl/game_controller_if.sv
// game_controller_if: frame/start/invader inputs and gating/score outputs of the game sequencer
interface game_controller_if #(
  parameter int NUM_INVADERS = 20,
  parameter int LINE_W       = 4
) ();
  logic                    vsync;
  logic                    start_debounced;
  logic [NUM_INVADERS-1:0] invaders_array;
  logic [LINE_W-1:0]       invaders_line;
  logic                    clear;
  logic                    clear_score;
  logic                    enable;
  logic [2:0]              level;
  logic [1:0]              lives;
  logic [2:0]              game_state;
  modport master (
    input  vsync, start_debounced, invaders_array, invaders_line,
    output clear, clear_score, enable, level, lives, game_state
  );
  modport slave (
    output vsync, start_debounced, invaders_array, invaders_line,
    input  clear, clear_score, enable, level, lives, game_state
  );
endinterface

// File: rtl/game_controller.sv
// game_controller: game sequencer gating player/invaders, tracking level, lives and game over
module game_controller #(
  parameter int BOTTOM_LINE  = 13,
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic clk_36MHz,
  input  logic reset,
  game_controller_if.master gif
);
  localparam int CW = $clog2(PAUSE_FRAMES + 1);
  typedef enum logic [2:0] {
    ATTRACT     = 3'd0,
    PAUSE_LEVEL = 3'd1,
    PLAY        = 3'd2,
    PAUSE_LIFE  = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    level_n;
  logic [1:0]    lives_n;
  logic          clear_score_n, vsync_q, start_q, frame_evt, start_evt, can_start;
  always_comb begin
    frame_evt     = vsync_q & ~gif.vsync;
    start_evt     = ~start_q & gif.start_debounced;
    can_start     = state == ATTRACT || (state == GAME_OVER && cnt == '0);
    state_n       = state;
    cnt_n         = (frame_evt && cnt != '0) ? cnt - CW'(1) : cnt;
    level_n       = gif.level;
    lives_n       = gif.lives;
    clear_score_n = 1'b0;
    case (state)
      ATTRACT, GAME_OVER:
        if (can_start && start_evt) begin
          clear_score_n = 1'b1;
          level_n       = 3'd0;
          lives_n       = 2'(LIVES_INIT);
          cnt_n         = CW'(PAUSE_FRAMES);
          state_n       = PAUSE_LEVEL;
        end
      PAUSE_LEVEL, PAUSE_LIFE:
        if (frame_evt && cnt == CW'(1)) state_n = PLAY;
      PLAY: begin
        cnt_n = cnt;
        // a cleared wave wins over a simultaneous invasion
        if (gif.invaders_array == '0) begin
          level_n = (gif.level == 3'(MAX_LEVEL)) ? gif.level : gif.level + 3'd1;
          cnt_n   = CW'(PAUSE_FRAMES);
          state_n = PAUSE_LEVEL;
        end else if (int'(gif.invaders_line) >= BOTTOM_LINE) begin
          lives_n = gif.lives - 2'd1;
          cnt_n   = CW'(PAUSE_FRAMES);
          state_n = (gif.lives > 2'd1) ? PAUSE_LIFE : GAME_OVER;
        end
      end
      default: state_n = ATTRACT;
    endcase
  end
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state           <= ATTRACT;
      cnt             <= '0;
      vsync_q         <= 1'b0;
      start_q         <= 1'b1;
      gif.clear       <= 1'b1;
      gif.clear_score <= 1'b0;
      gif.enable      <= 1'b0;
      gif.level       <= 3'd0;
      gif.lives       <= 2'(LIVES_INIT);
      gif.game_state  <= ATTRACT;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      vsync_q         <= gif.vsync;
      start_q         <= gif.start_debounced;
      gif.clear       <= state_n == ATTRACT || state_n == PAUSE_LEVEL || state_n == PAUSE_LIFE;
      gif.clear_score <= clear_score_n;
      gif.enable      <= state_n == PLAY;
      gif.level       <= level_n;
      gif.lives       <= lives_n;
      gif.game_state  <= state_n;
    end
  end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller
module tb_game_controller;
  logic clk_36MHz = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  game_controller_if gif ();
  game_controller dut (.clk_36MHz(clk_36MHz), .reset(reset), .gif(gif));
  always #5 clk_36MHz = ~clk_36MHz;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask
  task automatic frame();
    gif.vsync = 1'b1;
    tick();
    gif.vsync = 1'b0;
    tick();
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  task automatic press();
    gif.start_debounced = 1'b0;
    tick();
    gif.start_debounced = 1'b1;
    tick();
  endtask
  task automatic outs(input string tag, input int st, input int clr, input int en, input int lvl, input int lv);
    check({tag, ".state"}, gif.game_state, st);
    check({tag, ".clear"}, gif.clear, clr);
    check({tag, ".enable"}, gif.enable, en);
    check({tag, ".level"}, gif.level, lvl);
    check({tag, ".lives"}, gif.lives, lv);
  endtask
  task automatic to_play(input string tag);
    frames(59);
    check({tag, ".still_pause"}, gif.game_state == 2 ? 1 : 0, 0);
    frame();
    check({tag, ".play"}, gif.game_state, 2);
  endtask
  initial begin
    gif.vsync           = 1'b0;
    gif.start_debounced = 1'b1;
    gif.invaders_array  = 20'hFFFFF;
    gif.invaders_line   = 4'd0;
    // T1: start held through reset
    repeat (3) tick();
    outs("rst", 0, 1, 0, 0, 3);
    check("rst.cs", gif.clear_score, 0);
    reset = 1'b0;
    repeat (3) tick();
    outs("t1", 0, 1, 0, 0, 3);
    check("t1.cs", gif.clear_score, 0);
    // T2: new game
    press();
    check("t2.cs", gif.clear_score, 1);
    outs("t2", 1, 1, 0, 0, 3);
    tick();
    check("t2.cs_off", gif.clear_score, 0);
    to_play("t2");
    outs("t2p", 2, 0, 1, 0, 3);
    // T4: invasion, then wave clear with simultaneous invasion
    gif.invaders_array = 20'h00001;
    gif.invaders_line  = 4'd13;
    tick();
    outs("t4", 3, 1, 0, 0, 2);
    gif.invaders_line = 4'd0;
    to_play("t4");
    gif.invaders_array = 20'h0;
    gif.invaders_line  = 4'd13;
    tick();
    outs("t4b", 1, 1, 0, 1, 2);
    gif.invaders_array = 20'hFFFFF;
    gif.invaders_line  = 4'd0;
    // T3: cleared waves, level saturates at 7
    for (int w = 2; w <= 8; w++) begin
      to_play("t3");
      gif.invaders_array = 20'h0;
      tick();
      outs("t3", 1, 1, 0, (w > 7) ? 7 : w, 2);
      gif.invaders_array = 20'hFFFFF;
    end
    // T5: last lives lost, game over hold-off
    to_play("t5");
    gif.invaders_line = 4'd14;
    tick();
    outs("t5a", 3, 1, 0, 7, 1);
    gif.invaders_line = 4'd0;
    to_play("t5b");
    gif.invaders_line = 4'd13;
    tick();
    outs("t5go", 4, 0, 0, 7, 0);
    gif.invaders_line = 4'd0;
    frames(10);
    press();
    check("t5.ign_cs", gif.clear_score, 0);
    outs("t5ign", 4, 0, 0, 7, 0);
    frames(50);
    press();
    check("t5.cs", gif.clear_score, 1);
    outs("t5new", 1, 1, 0, 0, 3);
    // T6: reset mid-pause at counter 30
    frames(30);
    reset = 1'b1;
    tick();
    outs("t6a", 0, 1, 0, 0, 3);
    check("t6a.cs", gif.clear_score, 0);
    reset = 1'b0;
    tick();
    press();
    check("t6.cs", gif.clear_score, 1);
    to_play("t6");
    gif.invaders_array = 20'h0;
    tick();
    check("t6.lvl1", gif.level, 1);
    gif.invaders_array = 20'hFFFFF;
    to_play("t6b");
    reset = 1'b1;
    tick();
    outs("t6b", 0, 1, 0, 0, 3);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
